// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt take sequencer: vector low bytes,
// config register addresses and take-state encodings.
package int_ctrl_pkg;

   localparam logic [7:0] VEC_RST_LO = 8'hFC;
   localparam logic [7:0] VEC_NMI_LO = 8'hFA;
   localparam logic [7:0] VEC_IRQ_LO = 8'hFE;

   localparam logic [1:0] CFG_MASK = 2'd0;
   localparam logic [1:0] CFG_PEND = 2'd1;
   localparam logic [1:0] CFG_IDX  = 2'd2;

   typedef enum logic [1:0] {
      TAKE_RST = 2'd0,
      TAKE_NMI = 2'd1,
      TAKE_IRQ = 2'd2,
      RUN      = 2'd3
   } take_state_t;

   // Index of the lowest set bit, 0 when nothing is set.
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_set = 3'(i);
      end
   endfunction

endpackage

// File: rtl/int_sync.sv
// Parametrised-width two-flop synchronizer with a selectable reset value.
module int_sync
   import int_ctrl_pkg::*;
#(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt take sequencer: resolves rst/nmi/irq at instruction boundaries
// and supplies the vector low byte, with a small config/status port.
//
// state    | meaning
// TAKE_RST | reset sequence in progress, vec_lo = FC
// TAKE_NMI | NMI sequence in progress, vec_lo = FA
// TAKE_IRQ | IRQ sequence in progress, vec_lo = FE or per-source vector
// RUN      | normal execution, no take signal asserted
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int         N_SRC    = 4,
   parameter int         VECTORED = 0,
   parameter logic [7:0] VEC_BASE = 8'hE0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sync,
   input  logic             sr_i,
   input  logic             nmi_n,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             int_ack,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [7:0]       cfg_wdata,
   output logic [7:0]       cfg_rdata,
   output logic             rst,
   output logic             nmi,
   output logic             irq,
   output logic [7:0]       vec_lo
);

   logic [N_SRC-1:0] irq_sync;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] pend;
   logic [7:0]       pend8;
   logic [7:0]       mask8;
   logic             nmi_sync;
   logic             nmi_dly;
   logic             nmi_edge;
   logic             nmi_pend;
   logic             irq_req;
   logic             ack_seen;
   logic [2:0]       src_idx;
   logic [2:0]       src_idx_nxt;
   take_state_t      state;
   take_state_t      state_nxt;

   int_sync #(.W(N_SRC), .RST_VAL({N_SRC{1'b0}})) u_irq_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (irq_src),
      .q     (irq_sync)
   );

   int_sync #(.W(1), .RST_VAL(1'b1)) u_nmi_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (nmi_n),
      .q     (nmi_sync)
   );

   assign nmi_edge = nmi_dly & ~nmi_sync;
   assign pend     = irq_sync & mask;
   assign pend8    = 8'(pend);
   assign mask8    = 8'(mask);
   assign irq_req  = (|pend) & ~sr_i;

   // A fresh edge outranks the clearing ack so a back-to-back NMI is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nmi_dly  <= 1'b1;
         nmi_pend <= 1'b0;
         ack_seen <= 1'b0;
         mask     <= '0;
      end else begin
         nmi_dly  <= nmi_sync;
         nmi_pend <= nmi_edge | (nmi_pend & ~(int_ack & nmi));
         ack_seen <= (state == TAKE_RST) & (ack_seen | int_ack);
         if (cfg_we && (cfg_addr == CFG_MASK)) mask <= cfg_wdata[N_SRC-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= TAKE_RST;
         src_idx <= 3'd0;
      end else begin
         state   <= state_nxt;
         src_idx <= src_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      src_idx_nxt = src_idx;
      if (sync && ((state != TAKE_RST) || ack_seen)) begin
         src_idx_nxt = lowest_set(pend8);
         if (nmi_pend)     state_nxt = TAKE_NMI;
         else if (irq_req) state_nxt = TAKE_IRQ;
         else              state_nxt = RUN;
      end
   end

   assign rst = (state == TAKE_RST);
   assign nmi = (state == TAKE_NMI);
   assign irq = (state == TAKE_IRQ);

   always_comb begin
      vec_lo = VEC_IRQ_LO;
      case (state)
         TAKE_RST: vec_lo = VEC_RST_LO;
         TAKE_NMI: vec_lo = VEC_NMI_LO;
         TAKE_IRQ: vec_lo = (VECTORED != 0) ? (VEC_BASE + {4'd0, src_idx, 1'b0})
                                            : VEC_IRQ_LO;
         default:  vec_lo = VEC_IRQ_LO;
      endcase
   end

   always_comb begin
      cfg_rdata = 8'h00;
      case (cfg_addr)
         CFG_MASK: cfg_rdata = mask8;
         CFG_PEND: cfg_rdata = {nmi_pend, pend8[6:0]};
         CFG_IDX:  cfg_rdata = {5'd0, src_idx};
         default:  cfg_rdata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl (VECTORED=1, VEC_BASE=E0, N_SRC=4): directed vector
// table, hand-written reset corners, then random stimulus against a model.
module tb_int_ctrl;

   logic       clk;
   logic       rst_n;
   logic       sync;
   logic       sr_i;
   logic       nmi_n;
   logic [3:0] irq_src;
   logic       int_ack;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic [7:0] cfg_rdata;
   logic       rst;
   logic       nmi;
   logic       irq;
   logic [7:0] vec_lo;

   int checks;
   int failures;

   int_ctrl #(.N_SRC(4), .VECTORED(1), .VEC_BASE(8'hE0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sync      (sync),
      .sr_i      (sr_i),
      .nmi_n     (nmi_n),
      .irq_src   (irq_src),
      .int_ack   (int_ack),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .rst       (rst),
      .nmi       (nmi),
      .irq       (irq),
      .vec_lo    (vec_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // take kind: 0 reset, 1 nmi, 2 irq, 3 run
   typedef struct {
      bit         s;
      bit         sr;
      bit         nn;
      logic [3:0] src;
      bit         ack;
      bit         we;
      logic [1:0] a;
      logic [7:0] wd;
      int         take;
      logic [7:0] ev;
      logic [7:0] rd;
   } vec_t;

   vec_t tbl[$];

   function automatic void tv(bit s, bit sr, bit nn, logic [3:0] src, bit ack, bit we,
                              logic [1:0] a, logic [7:0] wd, int take, logic [7:0] ev,
                              logic [7:0] rd);
      vec_t v;
      v.s = s; v.sr = sr; v.nn = nn; v.src = src; v.ack = ack; v.we = we;
      v.a = a; v.wd = wd; v.take = take; v.ev = ev; v.rd = rd;
      tbl.push_back(v);
   endfunction

   // Behavioural model: pins delayed through arrays, then the priority rules.
   logic [3:0] m_irq_pipe[2];
   bit         m_nmi_pipe[3];
   bit         m_npend;
   logic [3:0] m_mask;
   int         m_take;
   bit         m_ack;
   int         m_idx;

   function automatic int lowest(logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [2:0] onehot(int take);
      case (take)
         0:       return 3'b100;
         1:       return 3'b010;
         2:       return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [7:0] take_vec(int take, int idx);
      case (take)
         0:       return 8'hFC;
         1:       return 8'hFA;
         default: return 8'hE0 + 8'(2 * idx);
      endcase
   endfunction

   task automatic model_reset();
      m_irq_pipe[0] = 4'h0; m_irq_pipe[1] = 4'h0;
      for (int i = 0; i < 3; i++) m_nmi_pipe[i] = 1'b1;
      m_npend = 1'b0; m_mask = 4'h0; m_take = 0; m_ack = 1'b0; m_idx = 0;
   endtask

   task automatic model_update();
      logic [3:0] pv;
      bit         req;
      bit         fell;
      bit         new_np;
      bit         new_ack;
      pv      = m_irq_pipe[1] & m_mask;
      req     = (pv != 4'h0) && !sr_i;
      fell    = m_nmi_pipe[2] && !m_nmi_pipe[1];
      new_np  = fell || (m_npend && !(int_ack && m_take == 1));
      new_ack = (m_take == 0) && (m_ack || int_ack);
      if (sync && (m_take != 0 || m_ack)) begin
         m_idx = lowest(pv);
         if (m_npend)  m_take = 1;
         else if (req) m_take = 2;
         else          m_take = 3;
      end
      m_npend = new_np;
      m_ack   = new_ack;
      if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[3:0];
      m_nmi_pipe[2] = m_nmi_pipe[1];
      m_nmi_pipe[1] = m_nmi_pipe[0];
      m_nmi_pipe[0] = nmi_n;
      m_irq_pipe[1] = m_irq_pipe[0];
      m_irq_pipe[0] = irq_src;
   endtask

   function automatic logic [7:0] model_rdata(logic [1:0] a);
      case (a)
         2'd0:    return {4'h0, m_mask};
         2'd1:    return {m_npend, 3'b000, m_irq_pipe[1] & m_mask};
         2'd2:    return 8'(m_idx);
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_check(string tag);
      chk({tag, "_take"}, {5'd0, rst, nmi, irq}, {5'd0, onehot(m_take)});
      if (m_take != 3) chk({tag, "_vec"}, vec_lo, take_vec(m_take, m_idx));
      chk({tag, "_rdata"}, cfg_rdata, model_rdata(cfg_addr));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      sync = 0; sr_i = 0; int_ack = 0; cfg_we = 0; cfg_wdata = 8'h00;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      nmi_n = 1'b1;
      irq_src = 4'h0;
      cfg_addr = 2'd0;
      idle_inputs();
      model_reset();

      #2;
      chk("reset_take", {5'd0, rst, nmi, irq}, 8'h04);
      chk("reset_vec", vec_lo, 8'hFC);
      for (int a = 0; a < 4; a++) begin
         cfg_addr = 2'(a);
         #1;
         chk($sformatf("reset_rdata%0d", a), cfg_rdata, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;

      //  s sr nn src ack we a  wd     take ev     rd
      tv(0,0,1,4'h0,0,0,2'd1,8'h00, 0,8'hFC,8'h00);
      tv(0,0,1,4'h0,1,0,2'd1,8'h00, 0,8'hFC,8'h00);
      tv(1,0,1,4'h0,0,0,2'd1,8'h00, 3,8'h00,8'h00);
      tv(0,0,1,4'h0,0,1,2'd0,8'hFF, 3,8'h00,8'h0F);
      tv(0,0,0,4'h0,0,0,2'd1,8'h00, 3,8'h00,8'h00);
      tv(0,0,0,4'h0,0,0,2'd1,8'h00, 3,8'h00,8'h00);
      tv(0,0,0,4'h0,0,0,2'd1,8'h00, 3,8'h00,8'h80);
      tv(1,0,0,4'h0,0,0,2'd1,8'h00, 1,8'hFA,8'h80);
      tv(0,0,0,4'h0,1,0,2'd1,8'h00, 1,8'hFA,8'h00);
      tv(1,0,1,4'h0,0,0,2'd1,8'h00, 3,8'h00,8'h00);
      tv(0,0,1,4'h6,0,0,2'd1,8'h00, 3,8'h00,8'h00);
      tv(0,0,1,4'h6,0,0,2'd1,8'h00, 3,8'h00,8'h06);
      tv(1,0,1,4'h6,0,0,2'd2,8'h00, 2,8'hE2,8'h01);
      tv(1,1,1,4'h6,0,0,2'd1,8'h00, 3,8'h00,8'h06);
      tv(0,0,0,4'h1,0,0,2'd1,8'h00, 3,8'h00,8'h06);
      tv(0,0,0,4'h1,0,0,2'd1,8'h00, 3,8'h00,8'h01);
      tv(0,0,0,4'h1,0,0,2'd1,8'h00, 3,8'h00,8'h81);
      tv(1,0,0,4'h1,0,0,2'd1,8'h00, 1,8'hFA,8'h81);
      tv(0,0,0,4'h1,1,0,2'd1,8'h00, 1,8'hFA,8'h01);
      tv(1,0,0,4'h1,0,0,2'd1,8'h00, 2,8'hE0,8'h01);
      tv(0,0,1,4'h0,0,0,2'd1,8'h00, 2,8'hE0,8'h01);
      tv(0,0,1,4'h0,0,0,2'd1,8'h00, 2,8'hE0,8'h00);
      tv(0,0,1,4'h0,0,0,2'd1,8'h00, 2,8'hE0,8'h00);
      tv(0,0,0,4'h0,0,0,2'd1,8'h00, 2,8'hE0,8'h00);
      tv(0,0,0,4'h0,0,0,2'd1,8'h00, 2,8'hE0,8'h00);
      tv(0,0,0,4'h0,0,0,2'd1,8'h00, 2,8'hE0,8'h80);
      tv(1,0,1,4'h0,0,0,2'd1,8'h00, 1,8'hFA,8'h80);
      tv(0,0,1,4'h0,0,0,2'd1,8'h00, 1,8'hFA,8'h80);
      tv(0,0,0,4'h0,0,0,2'd1,8'h00, 1,8'hFA,8'h80);
      tv(0,0,0,4'h0,0,0,2'd1,8'h00, 1,8'hFA,8'h80);
      tv(0,0,0,4'h0,1,0,2'd1,8'h00, 1,8'hFA,8'h80);
      tv(1,0,0,4'h0,0,0,2'd1,8'h00, 1,8'hFA,8'h80);
      tv(0,0,0,4'h0,1,0,2'd1,8'h00, 1,8'hFA,8'h00);
      tv(1,0,0,4'h0,0,0,2'd1,8'h00, 3,8'h00,8'h00);
      tv(0,0,0,4'h0,0,1,2'd3,8'hFF, 3,8'h00,8'h00);
      tv(0,0,0,4'h0,0,0,2'd0,8'h00, 3,8'h00,8'h0F);
      tv(0,0,0,4'h0,0,1,2'd0,8'h05, 3,8'h00,8'h05);

      foreach (tbl[i]) begin
         sync = tbl[i].s; sr_i = tbl[i].sr; nmi_n = tbl[i].nn; irq_src = tbl[i].src;
         int_ack = tbl[i].ack; cfg_we = tbl[i].we; cfg_addr = tbl[i].a;
         cfg_wdata = tbl[i].wd;
         step();
         chk($sformatf("v%0d_take", i), {5'd0, rst, nmi, irq}, {5'd0, onehot(tbl[i].take)});
         if (tbl[i].take != 3) chk($sformatf("v%0d_vec", i), vec_lo, tbl[i].ev);
         chk($sformatf("v%0d_rdata", i), cfg_rdata, tbl[i].rd);
      end

      // Mid-operation reset must discard a pending NMI and the mask.
      idle_inputs();
      cfg_addr = 2'd1;
      nmi_n = 1'b1;
      repeat (3) step();
      nmi_n = 1'b0;
      repeat (3) step();
      chk("pre_reset_nmi_pend", cfg_rdata, 8'h80);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midreset_take", {5'd0, rst, nmi, irq}, 8'h04);
      chk("midreset_vec", vec_lo, 8'hFC);
      chk("midreset_pend", cfg_rdata, 8'h00);
      cfg_addr = 2'd0;
      #1;
      chk("midreset_mask", cfg_rdata, 8'h00);
      nmi_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      sync = 1'b1;
      step();
      chk("sync_without_ack_take", {5'd0, rst, nmi, irq}, 8'h04);
      chk("sync_without_ack_vec", vec_lo, 8'hFC);

      for (int n = 0; n < 3000; n++) begin
         if (n % 700 == 650) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            model_check("rnd_reset");
            @(negedge clk);
            rst_n = 1'b1;
         end
         sync     = ($urandom_range(2) == 0);
         int_ack  = ($urandom_range(3) == 0);
         cfg_we   = ($urandom_range(9) == 0);
         cfg_addr = 2'($urandom_range(3));
         cfg_wdata = 8'($urandom);
         if ($urandom_range(9) == 0) sr_i = ~sr_i;
         if ($urandom_range(5) == 0) nmi_n = ~nmi_n;
         if ($urandom_range(7) == 0) irq_src = 4'($urandom);
         step();
         model_check($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
